spi_xfer_ctrl: RTL and testbench

- Wishbone master sequencer that sits directly upstream of the SPI core's Wishbone slave port.
- Accepts one transfer request per valid/ready handshake and programs the core's divider, slave-select, TX0 and CTRL registers.
- Waits for transfer completion, reads RX0, and returns the received word on a valid/ready response channel.
- Lets simple datapath logic drive the SPI core without a CPU.

---
 rtl/spi_xfer_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - Wishbone master sequencer that runs one SPI core transfer per request
module spi_xfer_ctrl #(
    parameter bit          USE_IRQ      = 1'b1,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned DONE_TIMEOUT = 65535
) (
    input  logic        wb_clk_in,
    input  logic        wb_rst_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_tx,
    input  logic [6:0]  req_len,
    input  logic [7:0]  req_ss,
    input  logic [15:0] req_div,
    input  logic [3:0]  req_mode,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rx,
    output logic        rsp_err,
    output logic        busy,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [4:0]  m_adr_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_int_i
);
    localparam logic [4:0] ADR_DATA = 5'h00;
    localparam logic [4:0] ADR_CTRL = 5'h10;
    localparam logic [4:0] ADR_DIV  = 5'h14;
    localparam logic [4:0] ADR_SS   = 5'h18;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_DIV, S_WR_SS, S_WR_TX, S_WR_CTRL, S_WAIT_DONE, S_RD_RX, S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d, we_q, we_d;
    logic [4:0]  adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] tx_q, tx_d;
    logic [6:0]  len_q, len_d;
    logic [7:0]  ss_q, ss_d, css_q, css_d;
    logic [15:0] div_q, div_d, cdiv_q, cdiv_d;
    logic [3:0]  mode_q, mode_d;
    logic        cache_valid_q, cache_valid_d;
    logic [31:0] ack_cnt_q, ack_cnt_d, done_cnt_q, done_cnt_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rx_q, rsp_rx_d;
    logic        bus_req, bus_we, acked, abort;
    logic [4:0]  bus_adr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_dat;

    assign req_ready = (state_q == S_IDLE) && wb_rst_in;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rx    = rsp_rx_q;
    assign rsp_err   = rsp_err_q;
    assign m_cyc_o   = cyc_q;
    assign m_stb_o   = cyc_q;
    assign m_we_o    = we_q;
    assign m_adr_o   = adr_q;
    assign m_sel_o   = sel_q;
    assign m_dat_o   = dat_q;

    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        we_d          = we_q;
        adr_d         = adr_q;
        sel_d         = sel_q;
        dat_d         = dat_q;
        tx_d          = tx_q;
        len_d         = len_q;
        ss_d          = ss_q;
        div_d         = div_q;
        mode_d        = mode_q;
        css_d         = css_q;
        cdiv_d        = cdiv_q;
        cache_valid_d = cache_valid_q;
        ack_cnt_d     = ack_cnt_q;
        done_cnt_d    = done_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_err_d     = rsp_err_q;
        rsp_rx_d      = rsp_rx_q;
        bus_req       = 1'b0;
        bus_we        = 1'b0;
        bus_adr       = '0;
        bus_sel       = '0;
        bus_dat       = '0;
        acked         = 1'b0;
        abort         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tx_d   = req_tx;
                    len_d  = req_len;
                    ss_d   = req_ss;
                    div_d  = req_div;
                    mode_d = req_mode;
                    if (!cache_valid_q || req_div != cdiv_q) state_d = S_WR_DIV;
                    else if (req_ss != css_q)               state_d = S_WR_SS;
                    else                                    state_d = S_WR_TX;
                end
            end
            S_WR_DIV: begin
                bus_req = 1'b1; bus_we = 1'b1; bus_adr = ADR_DIV;
                bus_sel = 4'b0011; bus_dat = {16'd0, div_q};
            end
            S_WR_SS: begin
                bus_req = 1'b1; bus_we = 1'b1; bus_adr = ADR_SS;
                bus_sel = 4'b0001; bus_dat = {24'd0, ss_q};
            end
            S_WR_TX: begin
                bus_req = 1'b1; bus_we = 1'b1; bus_adr = ADR_DATA;
                bus_sel = 4'b1111; bus_dat = tx_q;
            end
            S_WR_CTRL: begin
                bus_req = 1'b1; bus_we = 1'b1; bus_adr = ADR_CTRL; bus_sel = 4'b0011;
                bus_dat = {18'd0, mode_q[3], USE_IRQ, mode_q[2], mode_q[1], mode_q[0],
                           1'b1, 1'b0, len_q};
            end
            S_WAIT_DONE: begin
                if (!USE_IRQ) begin
                    bus_req = 1'b1; bus_adr = ADR_CTRL; bus_sel = 4'b1111;
                end
            end
            S_RD_RX: begin
                bus_req = 1'b1; bus_adr = ADR_DATA; bus_sel = 4'b1111;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared bus engine: raise the access, hold until ack, give up after ACK_TIMEOUT cycles
        if (bus_req) begin
            if (!cyc_q) begin
                cyc_d     = 1'b1;
                we_d      = bus_we;
                adr_d     = bus_adr;
                sel_d     = bus_sel;
                dat_d     = bus_dat;
                ack_cnt_d = '0;
            end else if (m_ack_i) begin
                acked = 1'b1;
            end else if (ack_cnt_q >= ACK_TIMEOUT - 1) begin
                abort = 1'b1;
            end else begin
                ack_cnt_d = ack_cnt_q + 32'd1;
            end
        end

        if (acked) begin
            cyc_d = 1'b0; we_d = 1'b0; adr_d = '0; sel_d = '0; dat_d = '0;
            case (state_q)
                S_WR_DIV: begin
                    cdiv_d  = div_q;
                    state_d = (cache_valid_q && ss_q == css_q) ? S_WR_TX : S_WR_SS;
                end
                S_WR_SS: begin
                    css_d         = ss_q;
                    cache_valid_d = 1'b1;
                    state_d       = S_WR_TX;
                end
                S_WR_TX:     state_d = S_WR_CTRL;
                S_WR_CTRL:   state_d = S_WAIT_DONE;
                S_WAIT_DONE: if (!m_dat_i[8]) state_d = S_RD_RX;
                S_RD_RX: begin
                    rsp_rx_d    = m_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
                default: ;
            endcase
        end

        if (state_q == S_WAIT_DONE) begin
            if (USE_IRQ && m_int_i) state_d = S_RD_RX;
            else if (state_d == S_WAIT_DONE && done_cnt_q >= DONE_TIMEOUT - 1) abort = 1'b1;
        end
        done_cnt_d = (state_q == S_WAIT_DONE && state_d == S_WAIT_DONE) ? done_cnt_q + 32'd1 : '0;

        // Any abort leaves the core in an unknown configuration, so the caches are dropped
        if (abort) begin
            cyc_d = 1'b0; we_d = 1'b0; adr_d = '0; sel_d = '0; dat_d = '0;
            ack_cnt_d     = '0;
            done_cnt_d    = '0;
            rsp_rx_d      = '0;
            rsp_err_d     = 1'b1;
            rsp_valid_d   = 1'b1;
            cache_valid_d = 1'b0;
            state_d       = S_RESP;
        end
    end

    always_ff @(posedge wb_clk_in) begin
        if (!wb_rst_in) begin
            state_q       <= S_IDLE;
            cyc_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            sel_q         <= '0;
            dat_q         <= '0;
            tx_q          <= '0;
            len_q         <= '0;
            ss_q          <= '0;
            div_q         <= '0;
            mode_q        <= '0;
            css_q         <= '0;
            cdiv_q        <= '0;
            cache_valid_q <= 1'b0;
            ack_cnt_q     <= '0;
            done_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rx_q      <= '0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            sel_q         <= sel_d;
            dat_q         <= dat_d;
            tx_q          <= tx_d;
            len_q         <= len_d;
            ss_q          <= ss_d;
            div_q         <= div_d;
            mode_q        <= mode_d;
            css_q         <= css_d;
            cdiv_q        <= cdiv_d;
            cache_valid_q <= cache_valid_d;
            ack_cnt_q     <= ack_cnt_d;
            done_cnt_q    <= done_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rx_q      <= rsp_rx_d;
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - scoreboard bench for spi_xfer_ctrl in interrupt and polling modes
module tb_spi_xfer_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_tx    [2];
    logic [6:0]  req_len   [2];
    logic [7:0]  req_ss    [2];
    logic [15:0] req_div   [2];
    logic [3:0]  req_mode  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rx    [2];
    logic        rsp_err   [2];
    logic        busy      [2];
    logic        m_cyc     [2];
    logic        m_stb     [2];
    logic        m_we      [2];
    logic [4:0]  m_adr     [2];
    logic [3:0]  m_sel     [2];
    logic [31:0] m_dat_o   [2];
    logic [31:0] m_dat_i   [2] = '{32'h0, 32'h0};
    logic        m_ack     [2] = '{1'b0, 1'b0};
    logic        m_int     [2];

    logic        seen      [2] = '{1'b0, 1'b0};
    int          stb_cnt   [2] = '{0, 0};
    int          acc_cnt   [2] = '{0, 0};
    logic        hold_en   [2];
    logic [4:0]  hold_adr  [2];
    logic [31:0] rx_val    [2];
    logic [31:0] ctrl_q    [2][$];
    logic [41:0] exp_bus   [2][$];
    logic [32:0] exp_rsp   [2][$];

    int n_pass  = 0;
    int n_total = 0;

    spi_xfer_ctrl #(.USE_IRQ(1'b1), .ACK_TIMEOUT(16), .DONE_TIMEOUT(64)) u_irq (
        .wb_clk_in(clk), .wb_rst_in(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_tx(req_tx[0]),
        .req_len(req_len[0]), .req_ss(req_ss[0]), .req_div(req_div[0]), .req_mode(req_mode[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rx(rsp_rx[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0]),
        .m_cyc_o(m_cyc[0]), .m_stb_o(m_stb[0]), .m_we_o(m_we[0]), .m_adr_o(m_adr[0]),
        .m_sel_o(m_sel[0]), .m_dat_o(m_dat_o[0]), .m_dat_i(m_dat_i[0]),
        .m_ack_i(m_ack[0]), .m_int_i(m_int[0])
    );

    spi_xfer_ctrl #(.USE_IRQ(1'b0), .ACK_TIMEOUT(16), .DONE_TIMEOUT(65535)) u_poll (
        .wb_clk_in(clk), .wb_rst_in(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_tx(req_tx[1]),
        .req_len(req_len[1]), .req_ss(req_ss[1]), .req_div(req_div[1]), .req_mode(req_mode[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rx(rsp_rx[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1]),
        .m_cyc_o(m_cyc[1]), .m_stb_o(m_stb[1]), .m_we_o(m_we[1]), .m_adr_o(m_adr[1]),
        .m_sel_o(m_sel[1]), .m_dat_o(m_dat_o[1]), .m_dat_i(m_dat_i[1]),
        .m_ack_i(m_ack[1]), .m_int_i(m_int[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [41:0] wr(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        return {1'b1, a, s, d};
    endfunction

    localparam logic [41:0] RD_RX   = {1'b0, 5'h00, 4'hF, 32'h0};
    localparam logic [41:0] RD_CTRL = {1'b0, 5'h10, 4'h0, 32'h0};

    // Slave model: acks one cycle after stb is seen, logs and scores each completed access
    always @(negedge clk) begin : slave
        logic [41:0] got;
        for (int g = 0; g < 2; g++) begin
            if (m_stb[g]) stb_cnt[g] = stb_cnt[g] + 1;
            if (m_cyc[g] && m_stb[g] && !m_ack[g] && !(hold_en[g] && m_adr[g] == hold_adr[g])) begin
                if (!seen[g]) begin
                    seen[g] = 1'b1;
                end else begin
                    seen[g]    = 1'b0;
                    m_ack[g]   = 1'b1;
                    acc_cnt[g] = acc_cnt[g] + 1;
                    if (!m_we[g]) begin
                        if (m_adr[g] == 5'h10)
                            m_dat_i[g] = (ctrl_q[g].size() > 0) ? ctrl_q[g].pop_front() : 32'h0;
                        else
                            m_dat_i[g] = rx_val[g];
                    end
                    got = {m_we[g], m_adr[g], (m_we[g] || m_adr[g] == 5'h00) ? m_sel[g] : 4'h0,
                           m_we[g] ? m_dat_o[g] : 32'h0};
                    check("bus_pending", 64'(exp_bus[g].size() > 0), 64'd1);
                    if (exp_bus[g].size() > 0) check("bus_access", 64'(got), 64'(exp_bus[g].pop_front()));
                end
            end else begin
                m_ack[g] = 1'b0;
                if (!m_cyc[g]) seen[g] = 1'b0;
            end
        end
    end

    task automatic send_req(input int g, input logic [31:0] tx, input logic [6:0] len,
                            input logic [7:0] ss, input logic [15:0] div, input logic [3:0] mode);
        int t = 0;
        req_tx[g] = tx; req_len[g] = len; req_ss[g] = ss; req_div[g] = div; req_mode[g] = mode;
        req_valid[g] = 1'b1;
        while (!req_ready[g] && t < 100) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        req_tx[g] = ~tx; req_len[g] = ~len; req_ss[g] = ~ss; req_div[g] = ~div; req_mode[g] = ~mode;
        check("accept", 64'(busy[g]), 64'd1);
    endtask

    task automatic wait_bus(input int g, input int n);
        int t = 0;
        while (exp_bus[g].size() > n && t < 1000) begin @(posedge clk); #1; t++; end
        check("wait_bus", 64'(exp_bus[g].size()), 64'(n));
    endtask

    task automatic wait_rsp(input int g, input int hold);
        int t = 0;
        logic [32:0] e;
        while (!rsp_valid[g] && t < 3000) begin @(posedge clk); #1; t++; end
        e = (exp_rsp[g].size() > 0) ? exp_rsp[g].pop_front() : 33'h1_DEAD_BEEF;
        check("rsp_valid", 64'(rsp_valid[g]), 64'd1);
        check("rsp_data", 64'({rsp_err[g], rsp_rx[g]}), 64'(e));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("rsp_hold", 64'({rsp_valid[g], req_ready[g], rsp_err[g], rsp_rx[g]}), 64'({2'b10, e}));
        end
        rsp_ready[g] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[g] = 1'b0;
        check("rsp_done", 64'({rsp_valid[g], busy[g], req_ready[g]}), 64'd1);
    endtask

    task automatic xfer_irq(input logic [31:0] tx, input logic [6:0] len, input logic [7:0] ss,
                            input logic [15:0] div, input logic [3:0] mode, input int hold);
        send_req(0, tx, len, ss, div, mode);
        wait_bus(0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("no_early_rd", 64'(exp_bus[0].size()), 64'd1);
        check("wait_state", 64'({busy[0], m_cyc[0]}), 64'd2);
        m_int[0] = 1'b1;
        wait_rsp(0, hold);
        m_int[0] = 1'b0;
    endtask

    initial begin
        int b;
        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b0; req_valid[g] = 1'b1; req_tx[g] = 32'hFFFF_FFFF; req_len[g] = 7'd1;
            req_ss[g] = 8'h1; req_div[g] = 16'h1; req_mode[g] = 4'h0; rsp_ready[g] = 1'b0;
            m_int[g] = 1'b0; hold_en[g] = 1'b0; hold_adr[g] = 5'h0; rx_val[g] = 32'h0;
        end
        repeat (3) begin
            @(posedge clk); #1;
            for (int g = 0; g < 2; g++) begin
                check("rst_ctl", 64'({req_ready[g], m_cyc[g], m_stb[g], m_we[g], m_adr[g], m_sel[g],
                                      rsp_valid[g], rsp_err[g], busy[g]}), 64'd0);
                check("rst_dat", {m_dat_o[g], rsp_rx[g]}, 64'd0);
            end
        end
        for (int g = 0; g < 2; g++) begin rst_n[g] = 1'b1; req_valid[g] = 1'b0; end
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) check("post_rst", 64'({req_ready[g], busy[g]}), 64'd2);

        // First transfer programs every register
        exp_bus[0].push_back(wr(5'h14, 4'b0011, 32'd4));
        exp_bus[0].push_back(wr(5'h18, 4'b0001, 32'd1));
        exp_bus[0].push_back(wr(5'h00, 4'b1111, 32'hA5A5_00FF));
        exp_bus[0].push_back(wr(5'h10, 4'b0011, 32'h0000_3108));
        exp_bus[0].push_back(RD_RX);
        exp_rsp[0].push_back({1'b0, 32'h3C});
        rx_val[0] = 32'h3C;
        xfer_irq(32'hA5A5_00FF, 7'd8, 8'h01, 16'd4, 4'b1000, 0);

        // Cached divider and slave select
        exp_bus[0].push_back(wr(5'h00, 4'b1111, 32'h0BAD_F00D));
        exp_bus[0].push_back(wr(5'h10, 4'b0011, 32'h0000_1920));
        exp_bus[0].push_back(RD_RX);
        exp_rsp[0].push_back({1'b0, 32'h55AA});
        rx_val[0] = 32'h55AA;
        xfer_irq(32'h0BAD_F00D, 7'd32, 8'h01, 16'd4, 4'b0100, 0);

        exp_bus[0].push_back(wr(5'h18, 4'b0001, 32'd2));
        exp_bus[0].push_back(wr(5'h00, 4'b1111, 32'h1));
        exp_bus[0].push_back(wr(5'h10, 4'b0011, 32'h0000_177F));
        exp_bus[0].push_back(RD_RX);
        exp_rsp[0].push_back({1'b0, 32'hFFFF_FFFF});
        rx_val[0] = 32'hFFFF_FFFF;
        xfer_irq(32'h1, 7'd127, 8'h02, 16'd4, 4'b0011, 0);

        // Ack timeout on the slave-select write
        hold_en[0] = 1'b1; hold_adr[0] = 5'h18;
        exp_rsp[0].push_back({1'b1, 32'h0});
        b = stb_cnt[0];
        send_req(0, 32'h11, 7'd8, 8'h04, 16'd4, 4'b0000);
        wait_rsp(0, 0);
        check("ack_to_stb_cycles", 64'(stb_cnt[0] - b), 64'd16);
        hold_en[0] = 1'b0;

        // Cache invalidated by the abort; response held under backpressure
        exp_bus[0].push_back(wr(5'h14, 4'b0011, 32'd4));
        exp_bus[0].push_back(wr(5'h18, 4'b0001, 32'd4));
        exp_bus[0].push_back(wr(5'h00, 4'b1111, 32'h22));
        exp_bus[0].push_back(wr(5'h10, 4'b0011, 32'h0000_1108));
        exp_bus[0].push_back(RD_RX);
        exp_rsp[0].push_back({1'b0, 32'h77});
        rx_val[0] = 32'h77;
        xfer_irq(32'h22, 7'd8, 8'h04, 16'd4, 4'b0000, 10);

        // Reset while waiting for completion
        exp_bus[0].push_back(wr(5'h00, 4'b1111, 32'h33));
        exp_bus[0].push_back(wr(5'h10, 4'b0011, 32'h0000_1108));
        send_req(0, 32'h33, 7'd8, 8'h04, 16'd4, 4'b0000);
        wait_bus(0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        check("mid_rst", 64'({m_cyc[0], m_stb[0], busy[0], req_ready[0], rsp_valid[0]}), 64'd0);
        rst_n[0] = 1'b1;
        m_int[0] = 1'b1;
        b = acc_cnt[0];
        repeat (20) @(posedge clk);
        #1;
        check("no_rd_after_rst", 64'(acc_cnt[0] - b), 64'd0);
        check("idle_after_rst", 64'({busy[0], m_cyc[0], req_ready[0]}), 64'd1);
        m_int[0] = 1'b0;

        // Completion never signalled: done timeout
        exp_bus[0].push_back(wr(5'h14, 4'b0011, 32'd4));
        exp_bus[0].push_back(wr(5'h18, 4'b0001, 32'd4));
        exp_bus[0].push_back(wr(5'h00, 4'b1111, 32'h44));
        exp_bus[0].push_back(wr(5'h10, 4'b0011, 32'h0000_1108));
        exp_rsp[0].push_back({1'b1, 32'h0});
        send_req(0, 32'h44, 7'd8, 8'h04, 16'd4, 4'b0000);
        wait_rsp(0, 0);

        // Polling mode: GO seen set twice, then clear
        ctrl_q[1].push_back(32'h0108);
        ctrl_q[1].push_back(32'h0108);
        ctrl_q[1].push_back(32'h0008);
        exp_bus[1].push_back(wr(5'h14, 4'b0011, 32'd2));
        exp_bus[1].push_back(wr(5'h18, 4'b0001, 32'd1));
        exp_bus[1].push_back(wr(5'h00, 4'b1111, 32'h1234_5678));
        exp_bus[1].push_back(wr(5'h10, 4'b0011, 32'h0000_2108));
        exp_bus[1].push_back(RD_CTRL);
        exp_bus[1].push_back(RD_CTRL);
        exp_bus[1].push_back(RD_CTRL);
        exp_bus[1].push_back(RD_RX);
        exp_rsp[1].push_back({1'b0, 32'h9A});
        rx_val[1] = 32'h9A;
        send_req(1, 32'h1234_5678, 7'd8, 8'h01, 16'd2, 4'b1000);
        wait_rsp(1, 0);
        check("poll_drained", 64'(exp_bus[1].size()), 64'd0);

        // Polling mode, CHAR_LEN=0 passed through, GO already clear on first read
        ctrl_q[1].push_back(32'h0000);
        exp_bus[1].push_back(wr(5'h00, 4'b1111, 32'hCAFE_BABE));
        exp_bus[1].push_back(wr(5'h10, 4'b0011, 32'h0000_0F00));
        exp_bus[1].push_back(RD_CTRL);
        exp_bus[1].push_back(RD_RX);
        exp_rsp[1].push_back({1'b0, 32'h5A5A_5A5A});
        rx_val[1] = 32'h5A5A_5A5A;
        send_req(1, 32'hCAFE_BABE, 7'd0, 8'h01, 16'd2, 4'b0111);
        wait_rsp(1, 0);
        check("poll_drained2", 64'(exp_bus[1].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
